// File: rtl/ok_adder_arbiter_if.sv
// Operand request / result response bundle shared by the requesters and the
// adder arbiter.
interface ok_adder_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;
    logic [IDW-1:0]        rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
    );
endinterface

// File: rtl/ok_adder_arbiter.sv
// One registered adder shared round-robin among NREQ operand requesters;
// each issued sum is tagged with its requester id and counted.
module ok_adder_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
) (
    input  logic            okClk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [NREQ-1:0] req_mask,
    ok_adder_arbiter_if.slave bus,
    output logic [31:0]     xfer_count
);
    logic [NREQ-1:0][WIDTH-1:0] a_vec, b_vec;
    logic [NREQ-1:0]            elig;
    logic [NREQ-1:0]            grant;
    logic [IDW-1:0]             ptr;
    logic [IDW-1:0]             gidx;
    logic                       xfer;
    logic                       slot_free;

    assign a_vec     = bus.req_a;
    assign b_vec     = bus.req_b;
    assign elig      = bus.req_valid & ~req_mask;
    assign slot_free = ~bus.rsp_valid | bus.rsp_ready;

    // Rotating priority search starting at ptr; gated by rst_n so nothing is
    // granted while reset is held.
    always_comb begin
        int idx;
        grant = '0;
        gidx  = '0;
        xfer  = 1'b0;
        idx   = 0;
        if (rst_n && enable && slot_free) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!xfer && elig[idx]) begin
                    xfer       = 1'b1;
                    grant[idx] = 1'b1;
                    gidx       = IDW'(idx);
                end
            end
        end
    end

    assign bus.req_ready = grant;

    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_carry <= 1'b0;
            bus.rsp_id    <= '0;
            xfer_count    <= '0;
        end else if (xfer) begin
            ptr           <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
            bus.rsp_valid <= 1'b1;
            {bus.rsp_carry, bus.rsp_sum} <= {1'b0, a_vec[gidx]} + {1'b0, b_vec[gidx]};
            bus.rsp_id    <= gidx;
            xfer_count    <= xfer_count + 32'd1;
        end else if (bus.rsp_ready) begin
            // Drain without reload: data fields keep their last value.
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ok_adder_arbiter.sv
// Directed bench for ok_adder_arbiter: reset, add/overflow, fairness,
// backpressure, mask/enable and asynchronous reset mid-stream.
module tb_ok_adder_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    logic            okClk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [NREQ-1:0] req_mask;
    logic [31:0]     xfer_count;
    int              checks   = 0;
    int              failures = 0;

    ok_adder_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    ok_adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .okClk      (okClk),
        .rst_n      (rst_n),
        .enable     (enable),
        .req_mask   (req_mask),
        .bus        (bus.slave),
        .xfer_count (xfer_count)
    );

    always #5 okClk = ~okClk;

    task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[r*WIDTH +: WIDTH] = a;
        bus.req_b[r*WIDTH +: WIDTH] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge okClk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; req_mask = '0;
        bus.req_valid = 4'b1111; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b1;
        @(negedge okClk);
        checks++;
        if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0 || bus.rsp_sum !== 32'd0 ||
            bus.rsp_carry !== 1'b0 || bus.rsp_id !== 2'd0 || xfer_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: ready=%b vld=%b sum=%h c=%b id=%0d cnt=%0d, want all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_sum, bus.rsp_carry, bus.rsp_id, xfer_count);
        end
        bus.req_valid = '0;
        @(posedge okClk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        set_ops(0, 32'd5, 32'd7);
        bus.req_valid = 4'b0001;
        @(negedge okClk);
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++; $display("FAIL single_grant: got %b want 0001", bus.req_ready);
        end
        @(posedge okClk); #1;
        bus.req_valid = '0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'd12 || bus.rsp_carry !== 1'b0 ||
            bus.rsp_id !== 2'd0 || xfer_count !== 32'd1) begin
            failures++;
            $display("FAIL single_result: vld=%b sum=%0d c=%b id=%0d cnt=%0d want 1 12 0 0 1",
                     bus.rsp_valid, bus.rsp_sum, bus.rsp_carry, bus.rsp_id, xfer_count);
        end
    endtask

    task automatic test_overflow();
        // ptr is now 1, so use requester 1
        set_ops(1, 32'hFFFF_FFFF, 32'd2);
        bus.req_valid = 4'b0010;
        @(negedge okClk);
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            failures++; $display("FAIL ovf_grant: got %b want 0010", bus.req_ready);
        end
        @(posedge okClk); #1;
        bus.req_valid = '0;
        checks++;
        if (bus.rsp_sum !== 32'h0000_0001 || bus.rsp_carry !== 1'b1 || bus.rsp_id !== 2'd1 ||
            xfer_count !== 32'd2) begin
            failures++;
            $display("FAIL ovf_result: sum=%h c=%b id=%0d cnt=%0d want 00000001 1 1 2",
                     bus.rsp_sum, bus.rsp_carry, bus.rsp_id, xfer_count);
        end
        @(posedge okClk); #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== 32'h0000_0001) begin
            failures++;
            $display("FAIL drain_only: vld=%b sum=%h want 0 00000001", bus.rsp_valid, bus.rsp_sum);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 32'(10 + i), 32'(1000 * i));
        bus.req_valid = 4'b1111; bus.rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge okClk);
            checks++;
            if (bus.req_ready !== 4'(1 << (k % 4))) begin
                failures++;
                $display("FAIL fair_grant[%0d]: got %b want %b", k, bus.req_ready, 4'(1 << (k % 4)));
            end
            @(posedge okClk); #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(k % 4) ||
                bus.rsp_sum !== 32'(10 + 1001 * (k % 4))) begin
                failures++;
                $display("FAIL fair_rsp[%0d]: vld=%b id=%0d sum=%0d want 1 %0d %0d", k,
                         bus.rsp_valid, bus.rsp_id, bus.rsp_sum, k % 4, 10 + 1001 * (k % 4));
            end
        end
        checks++;
        if (xfer_count !== 32'd6) begin
            failures++; $display("FAIL fair_count: got %0d want 6", xfer_count);
        end
    endtask

    task automatic test_backpressure();
        // holding id 1 (sum 1011), ptr = 2
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge okClk);
            checks++;
            if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 ||
                bus.rsp_sum !== 32'd1011 || bus.rsp_carry !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: ready=%b vld=%b id=%0d sum=%0d want 0000 1 1 1011",
                         k, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_sum);
            end
            @(posedge okClk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge okClk);
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            failures++; $display("FAIL bp_release_grant: got %b want 0100", bus.req_ready);
        end
        @(posedge okClk); #1;
        checks++;
        if (bus.rsp_id !== 2'd2 || bus.rsp_sum !== 32'd2012 || xfer_count !== 32'd7) begin
            failures++;
            $display("FAIL bp_release_rsp: id=%0d sum=%0d cnt=%0d want 2 2012 7",
                     bus.rsp_id, bus.rsp_sum, xfer_count);
        end
    endtask

    task automatic test_mask_enable();
        logic [1:0] exp_id [3] = '{2'd1, 2'd3, 2'd1};
        req_mask = 4'b0101;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge okClk);
            checks++;
            if (bus.req_ready !== 4'(1 << exp_id[k])) begin
                failures++;
                $display("FAIL mask_grant[%0d]: got %b want %b", k, bus.req_ready, 4'(1 << exp_id[k]));
            end
            @(posedge okClk); #1;
            checks++;
            if (bus.rsp_id !== exp_id[k]) begin
                failures++; $display("FAIL mask_rsp[%0d]: id=%0d want %0d", k, bus.rsp_id, exp_id[k]);
            end
        end
        // ptr is 2 now; disabled arbitration must drain and not move it
        enable = 1'b0; req_mask = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge okClk);
            checks++;
            if (bus.req_ready !== 4'b0000) begin
                failures++; $display("FAIL dis_grant[%0d]: got %b want 0000", k, bus.req_ready);
            end
            @(posedge okClk); #1;
        end
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd1 || xfer_count !== 32'd3) begin
            failures++;
            $display("FAIL dis_drain: vld=%b id=%0d cnt=%0d want 0 1 3",
                     bus.rsp_valid, bus.rsp_id, xfer_count);
        end
        enable = 1'b1;
        @(negedge okClk);
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            failures++; $display("FAIL reenable_grant: got %b want 0100", bus.req_ready);
        end
        @(posedge okClk); #1;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2) begin
            failures++;
            $display("FAIL reenable_rsp: vld=%b id=%0d want 1 2", bus.rsp_valid, bus.rsp_id);
        end
    endtask

    task automatic test_reset_midstream();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== 32'd0 || bus.rsp_carry !== 1'b0 ||
            bus.rsp_id !== 2'd0 || xfer_count !== 32'd0 || bus.req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset: vld=%b sum=%h id=%0d cnt=%0d ready=%b want all 0",
                     bus.rsp_valid, bus.rsp_sum, bus.rsp_id, xfer_count, bus.req_ready);
        end
        @(negedge okClk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++; $display("FAIL post_reset_grant: got %b want 0001", bus.req_ready);
        end
        @(posedge okClk); #1;
        checks++;
        if (bus.rsp_id !== 2'd0 || bus.rsp_sum !== 32'd10 || xfer_count !== 32'd1) begin
            failures++;
            $display("FAIL post_reset_rsp: id=%0d sum=%0d cnt=%0d want 0 10 1",
                     bus.rsp_id, bus.rsp_sum, xfer_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_overflow();
        test_fairness();
        test_backpressure();
        test_mask_enable();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
